flag_update_unit: RTL and testbench
===================================

// Module: flag_update_unit
// PURPOSE
//  Producer side of the branch-condition flags: computes, registers and forwards the Z/V/N flag vector
//  consumed by the next-PC/branch logic as f[2:0] = {Z,V,N}. Sits at the EX/MEM boundary of the pipeline.
//  Applies the per-opcode flag-write rules, resolves flag hazards for a branch in ID,
//  and latches the HLT condition.
// PARAMETERS
//  FORWARD     1   1: bypass EX flag result to flags_fwd, no stall; 0: stall branch in ID one cycle instead
//  CNT_W       16  width of the flag-update event counter
// PORTS
//  clk            in   1      clock
//  rst            in   1      synchronous active-high reset
//  ex_valid       in   1      EX stage holds a real (non-bubble) instruction
//  ex_opcode      in   4      opcode of EX instruction (ISA encoding)
//  ex_result      in   16     ALU result of EX instruction (post-saturation)
//  ex_ovfl        in   1      ALU overflow/saturation indicator for EX instruction
//  stall          in   1      pipeline stall: EX instruction does not retire this cycle
//  flush          in   1      squash EX instruction (mispredict/redirect)
//  id_branch      in   1      ID stage holds B or BR
//  flags_q        out  3      architectural flag register {Z,V,N}
//  flags_fwd      out  3      flags to present to branch logic this cycle {Z,V,N}
//  hazard_stall   out  1      request one-cycle ID stall for flag hazard
//  halted         out  1      HLT has retired; sticky until reset
//  flag_upd_cnt   out  CNT_W  count of retired flag-writing instructions, wraps
// BEHAVIOUR
//  Reset: flags_q=3'b000, halted=0, flag_upd_cnt=0; hazard_stall/flags_fwd follow from these (flags_fwd=000).
//  Write masks by opcode: ADD 0000, SUB 0001 -> Z,V,N; XOR 0010, SLL 0100, SRA 0101, ROR 0110 -> Z only;
//   all other opcodes -> none (unmasked flags hold their value).
//  Next values: Z = (ex_result==16'h0000); V = ex_ovfl; N = ex_result[15].
//  Retire condition: ret = ex_valid & ~stall & ~flush & ~halted.
//  Priority at posedge: rst > flush > stall > update. Flush or stall: no flag, count or halted change.
//  Update: on ret, masked bits of flags_q take next values (latency 1: visible on flags_q next cycle);
//   if mask nonzero, flag_upd_cnt += 1, modulo 2^CNT_W (all-ones wraps to 0).
//  HLT (1111) with ret sets halted=1; every later instruction is ignored until rst. HLT writes no flags.
//  ex_wr = ex_valid & ~flush & ~halted & (mask!=0). stall is not in ex_wr: the flags stay pending during a stall.
//  flags_fwd (combinational):
//   FORWARD=1 and ex_wr -> flags_q with masked bits replaced by next values; otherwise flags_q.
//  hazard_stall (combinational) = (FORWARD==0) & id_branch & ex_wr. It deasserts once the writer leaves EX.
//   With FORWARD=1 it is tied 0.
//  Back-to-back writers: each retires in order; a Z-only writer after ADD keeps ADD's V,N.
//  Reset mid-operation: rst during a stall or a HLT cycle wins; the state returns to reset values next cycle.
//  No combinational path from flags_q to ex_* inputs; ex_* inputs feed flags_fwd/hazard_stall combinationally.
// TESTING
//  1. rst held 2 cycles then released -> flags_q=000, halted=0, cnt=0, flags_fwd=000.
//  2. ADD result=16'h0000, ovfl=0 retires -> next cycle flags_q=100, cnt=1.
//     Then SUB result=16'h8000, ovfl=1 -> flags_q=011, cnt=2.
//  3. flags_q=011; XOR result=16'h0000 -> flags_q=111 (V,N kept).
//     Then LW result=0 -> flags_q unchanged, cnt unchanged.
//  4. FORWARD=1: ADD result=16'hFFFF in EX with id_branch=1 -> same cycle flags_fwd=001, hazard_stall=0.
//     FORWARD=0, same stimulus -> hazard_stall=1 for that cycle, flags_fwd=flags_q.
//  5. SUB with stall=1 for 3 cycles -> flags_q unchanged until stall drops; then updates once, cnt+1.
//     SUB with flush=1 -> no update.
//  6. HLT retires -> halted=1. Following ADD result=0 -> no flag/cnt change. Preload cnt=16'hFFFF + ADD -> cnt=0.

Source files
------------

// File: rtl/flag_update_unit_if.sv
// Bundles the EX-stage flag-producer inputs and the flag/branch outputs.
// slave = the flag update unit, master = the pipeline side that drives EX.
interface flag_update_unit_if #(
   parameter int CNT_W = 16
);
   logic             ex_valid;
   logic [3:0]       ex_opcode;
   logic [15:0]      ex_result;
   logic             ex_ovfl;
   logic             stall;
   logic             flush;
   logic             id_branch;
   logic [2:0]       flags_q;
   logic [2:0]       flags_fwd;
   logic             hazard_stall;
   logic             halted;
   logic [CNT_W-1:0] flag_upd_cnt;

   modport slave (
      input  ex_valid, ex_opcode, ex_result, ex_ovfl, stall, flush, id_branch,
      output flags_q, flags_fwd, hazard_stall, halted, flag_upd_cnt
   );

   modport master (
      output ex_valid, ex_opcode, ex_result, ex_ovfl, stall, flush, id_branch,
      input  flags_q, flags_fwd, hazard_stall, halted, flag_upd_cnt
   );
endinterface

// File: rtl/flag_update_unit.sv
// Computes, registers and forwards the {Z,V,N} branch flags at the EX/MEM boundary,
// resolves the flag hazard for a branch in ID and latches the HLT condition.
module flag_update_unit #(
   parameter int FORWARD = 1,
   parameter int CNT_W   = 16
) (
   input  logic                clk,
   input  logic                rst,
   flag_update_unit_if.slave   bus
);
   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_XOR = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b0100;
   localparam logic [3:0] OP_SRA = 4'b0101;
   localparam logic [3:0] OP_ROR = 4'b0110;
   localparam logic [3:0] OP_HLT = 4'b1111;
   localparam logic       FWD_EN = (FORWARD != 0);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [2:0]       flags_q, flags_d;
   logic             halted_q, halted_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [2:0] wr_mask;
   logic [2:0] flags_new;
   logic [2:0] flags_merged;
   logic       ret;
   logic       ex_wr;

   always_comb begin
      wr_mask = 3'b000;
      case (bus.ex_opcode)
         OP_ADD, OP_SUB:                 wr_mask = 3'b111;
         OP_XOR, OP_SLL, OP_SRA, OP_ROR: wr_mask = 3'b100;
         default:                        wr_mask = 3'b000;
      endcase
   end

   assign flags_new    = {(bus.ex_result == 16'h0000), bus.ex_ovfl, bus.ex_result[15]};
   assign flags_merged = (flags_q & ~wr_mask) | (flags_new & wr_mask);

   assign ret   = bus.ex_valid & ~bus.stall & ~bus.flush & ~halted_q;
   // Stall is deliberately left out: a stalled writer still owns the pending flags.
   assign ex_wr = bus.ex_valid & ~bus.flush & ~halted_q & (wr_mask != 3'b000);

   always_comb begin
      flags_d  = flags_q;
      halted_d = halted_q;
      cnt_d    = cnt_q;
      if (ret) begin
         flags_d = flags_merged;
         if (wr_mask != 3'b000) begin
            cnt_d = cnt_q + CNT_ONE;
         end
         if (bus.ex_opcode == OP_HLT) begin
            halted_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q  <= 3'b000;
         halted_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         flags_q  <= flags_d;
         halted_q <= halted_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.flags_q      = flags_q;
   assign bus.halted       = halted_q;
   assign bus.flag_upd_cnt = cnt_q;
   assign bus.flags_fwd    = (FWD_EN && ex_wr) ? flags_merged : flags_q;
   assign bus.hazard_stall = ~FWD_EN & bus.id_branch & ex_wr;
endmodule

// File: tb/tb_flag_update_unit.sv
// Self-checking bench: a forwarding instance (CNT_W=16) and a stalling instance
// (CNT_W=3, so counter wrap is reachable) see identical stimulus; a scoreboard holds expected state.
module tb_flag_update_unit;
   logic clk;
   logic rst;

   flag_update_unit_if #(.CNT_W(16)) if_a ();
   flag_update_unit_if #(.CNT_W(3))  if_b ();

   flag_update_unit #(.FORWARD(1), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
   flag_update_unit #(.FORWARD(0), .CNT_W(3))  dut_b (.clk(clk), .rst(rst), .bus(if_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  flags;
      logic        halted;
      logic [15:0] cnt_a;
      logic [2:0]  cnt_b;
   } exp_t;

   exp_t sbq[$];

   int checks = 0;
   int errors = 0;
   int txn    = 0;

   logic [2:0]  m_flags  = 3'b000;
   logic        m_halted = 1'b0;
   logic [15:0] m_cnt_a  = 16'h0;
   logic [2:0]  m_cnt_b  = 3'h0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [2:0] mask_of(input logic [3:0] op);
      case (op)
         4'h0, 4'h1:             return 3'b111;
         4'h2, 4'h4, 4'h5, 4'h6: return 3'b100;
         default:                return 3'b000;
      endcase
   endfunction

   // Drive one cycle of stimulus, check combinational outputs mid-cycle,
   // push the expected post-edge state and compare it after the edge.
   task automatic step(input logic r, input logic v, input logic [3:0] op,
                       input logic [15:0] res, input logic ov, input logic st,
                       input logic fl, input logic br);
      logic [2:0] m;
      logic [2:0] nv;
      logic [2:0] merged;
      logic       wr;
      logic       ret;
      exp_t       e;
      m      = mask_of(op);
      nv     = {(res == 16'h0000), ov, res[15]};
      merged = (m_flags & ~m) | (nv & m);
      wr     = v & ~fl & ~m_halted & (m != 3'b000);
      ret    = v & ~st & ~fl & ~m_halted;

      rst = r;
      if_a.ex_valid = v;   if_b.ex_valid = v;
      if_a.ex_opcode = op; if_b.ex_opcode = op;
      if_a.ex_result = res; if_b.ex_result = res;
      if_a.ex_ovfl = ov;   if_b.ex_ovfl = ov;
      if_a.stall = st;     if_b.stall = st;
      if_a.flush = fl;     if_b.flush = fl;
      if_a.id_branch = br; if_b.id_branch = br;

      @(negedge clk);
      if (!r) begin
         chk("fwd_a", {29'd0, if_a.flags_fwd}, {29'd0, (wr ? merged : m_flags)});
         chk("haz_a", {31'd0, if_a.hazard_stall}, 32'd0);
         chk("fwd_b", {29'd0, if_b.flags_fwd}, {29'd0, m_flags});
         chk("haz_b", {31'd0, if_b.hazard_stall}, {31'd0, br & wr});
      end

      if (r) begin
         m_flags = 3'b000; m_halted = 1'b0; m_cnt_a = 16'h0; m_cnt_b = 3'h0;
      end else if (ret) begin
         m_flags = merged;
         if (m != 3'b000) begin
            m_cnt_a = m_cnt_a + 16'd1;
            m_cnt_b = m_cnt_b + 3'd1;
         end
         if (op == 4'hF) m_halted = 1'b1;
      end
      sbq.push_back('{flags: m_flags, halted: m_halted, cnt_a: m_cnt_a, cnt_b: m_cnt_b});

      @(posedge clk);
      #1;
      e = sbq.pop_front();
      chk("flags_a", {29'd0, if_a.flags_q}, {29'd0, e.flags});
      chk("flags_b", {29'd0, if_b.flags_q}, {29'd0, e.flags});
      chk("halt_a", {31'd0, if_a.halted}, {31'd0, e.halted});
      chk("halt_b", {31'd0, if_b.halted}, {31'd0, e.halted});
      chk("cnt_a", {16'd0, if_a.flag_upd_cnt}, {16'd0, e.cnt_a});
      chk("cnt_b", {29'd0, if_b.flag_upd_cnt}, {29'd0, e.cnt_b});
      txn++;
      $display("txn %0d rst=%0b v=%0b op=%h res=%h ov=%0b st=%0b fl=%0b br=%0b -> flags=%b halted=%0b cnt=%0d/%0d",
               txn, r, v, op, res, ov, st, fl, br, if_a.flags_q, if_a.halted,
               if_a.flag_upd_cnt, if_b.flag_upd_cnt);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [2:0]  cb;
      logic [15:0] ca;
      logic [3:0]  ops [8];
      ops = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h3};

      rst = 1'b1;
      @(posedge clk);
      #1;
      // Reset held two cycles, then released
      step(1, 0, 4'h0, 16'h0, 0, 0, 0, 0);
      step(1, 0, 4'h0, 16'h0, 0, 0, 0, 0);
      chk("rst_flags", {29'd0, if_a.flags_q}, 32'd0);
      chk("rst_fwd", {29'd0, if_a.flags_fwd}, 32'd0);
      chk("rst_cnt", {16'd0, if_a.flag_upd_cnt}, 32'd0);
      step(0, 0, 4'h0, 16'h0, 0, 0, 0, 0);

      step(0, 1, 4'h0, 16'h0000, 0, 0, 0, 0);
      chk("add_z", {29'd0, if_a.flags_q}, 32'b100);
      chk("add_cnt", {16'd0, if_a.flag_upd_cnt}, 32'd1);
      step(0, 1, 4'h1, 16'h8000, 1, 0, 0, 0);
      chk("sub_vn", {29'd0, if_a.flags_q}, 32'b011);
      chk("sub_cnt", {16'd0, if_a.flag_upd_cnt}, 32'd2);
      step(0, 1, 4'h2, 16'h0000, 0, 0, 0, 0);
      chk("xor_keep", {29'd0, if_a.flags_q}, 32'b111);
      step(0, 1, 4'h8, 16'h0000, 0, 0, 0, 0);
      chk("lw_none", {29'd0, if_a.flags_q}, 32'b111);
      chk("lw_cnt", {16'd0, if_a.flag_upd_cnt}, 32'd3);

      // Branch in ID with a flag writer in EX
      step(0, 1, 4'h0, 16'hFFFF, 0, 0, 0, 1);
      chk("br_flags", {29'd0, if_a.flags_q}, 32'b001);

      // Stalled writer stays pending, then retires once
      repeat (3) step(0, 1, 4'h1, 16'h0000, 0, 1, 0, 1);
      chk("stall_hold", {29'd0, if_a.flags_q}, 32'b001);
      step(0, 1, 4'h1, 16'h0000, 0, 0, 0, 1);
      chk("stall_upd", {29'd0, if_a.flags_q}, 32'b100);
      chk("stall_cnt", {16'd0, if_a.flag_upd_cnt}, 32'd5);
      step(0, 1, 4'h1, 16'h8000, 1, 0, 1, 1);
      chk("flush_none", {29'd0, if_a.flags_q}, 32'b100);

      for (int i = 0; i < 24; i++) begin
         step(0, ($urandom_range(0, 4) != 0), ops[$urandom_range(0, 7)],
              ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom()),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
      end

      // Eight writers wrap the 3-bit counter back to its starting value
      cb = if_b.flag_upd_cnt;
      ca = if_a.flag_upd_cnt;
      repeat (8) step(0, 1, 4'h0, 16'h0001, 0, 0, 0, 0);
      chk("wrap_b", {29'd0, if_b.flag_upd_cnt}, {29'd0, cb});
      chk("cnt_a8", {16'd0, if_a.flag_upd_cnt}, {16'd0, ca + 16'd8});

      step(0, 1, 4'hF, 16'h0000, 0, 0, 0, 0);
      chk("hlt", {31'd0, if_a.halted}, 32'd1);
      chk("hlt_flags", {29'd0, if_a.flags_q}, 32'b000);
      ca = if_a.flag_upd_cnt;
      step(0, 1, 4'h0, 16'h0000, 1, 0, 0, 1);
      chk("post_hlt", {29'd0, if_a.flags_q}, 32'b000);
      chk("post_hlt_cnt", {16'd0, if_a.flag_upd_cnt}, {16'd0, ca});

      // Reset wins over a HLT cycle and over a stall
      step(1, 1, 4'hF, 16'h0000, 0, 0, 0, 0);
      chk("rst_hlt", {31'd0, if_a.halted}, 32'd0);
      step(0, 1, 4'h1, 16'h8000, 1, 0, 0, 0);
      step(1, 1, 4'h1, 16'h0000, 0, 1, 0, 1);
      chk("rst_stall", {29'd0, if_a.flags_q}, 32'd0);
      step(0, 1, 4'h6, 16'h0000, 0, 0, 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
